// File: rtl/control_directional_mode.sv
// AV1 directional intra predictor for one 4x4 block: inputs captured, prediction registered (2-clock latency).
// Optional edge smoothing is compiled in by defining INTRA_EDGE_FILTER_EN.
module control_directional_mode #(
  parameter int BITDEPTH = 10,
  parameter int NCOMP    = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                plane,
  input  logic                                haveLeft,
  input  logic                                haveAbove,
  input  logic [3:0]                          mode,
  input  logic signed [9:0]                   AngleDeltaY,
  input  logic signed [9:0]                   AngleDeltaUV,
  input  logic [NCOMP*BITDEPTH-1:0]           referencePixel,
  input  logic                                enable_intra_edge_filter,
  input  logic [15:0]                         maxX,
  input  logic [15:0]                         maxY,
  input  logic signed [9:0]                   base_angle,
  input  logic [9:0]                          w,
  input  logic [9:0]                          h,
  input  logic [15:0]                         x,
  input  logic [15:0]                         y,
  input  logic [7:0][NCOMP*BITDEPTH-1:0]      aboveRow,
  input  logic [7:0][NCOMP*BITDEPTH-1:0]      leftCol,
  output logic [3:0][3:0][NCOMP*BITDEPTH-1:0] pred
);
  localparam int PW     = NCOMP * BITDEPTH;
  localparam int ACC_W  = BITDEPTH + 6;
  localparam logic [BITDEPTH-1:0] PIX_MAX = '1;

  logic              plane_r, have_left_r, have_above_r, filt_en_r;
  logic [3:0]        mode_r;
  logic signed [9:0] delta_y_r, delta_uv_r, base_angle_r;
  logic [PW-1:0]     ref_pix_r;
  logic [15:0]       max_x_r, max_y_r, x_r, y_r;
  logic [9:0]        w_r, h_r;
  logic [7:0][PW-1:0] above_r, left_r;

  logic signed [11:0] delta_s, p_angle_s;
  logic [9:0]        dx_s, dy_s;
  logic [2:0]        lim_a_s, lim_l_s, ia_s, il_s;
  logic [PW-1:0]     ea_s [0:8];
  logic [PW-1:0]     la_s [0:8];
  logic [PW-1:0]     af_s [0:8];
  logic [PW-1:0]     lf_s [0:8];
  logic [3:0][3:0][PW-1:0] pred_s;
  int                idx_s, base_s, bl_s;
  logic [4:0]        sh_s;
  logic              fill_s;
  logic              unused_s;

  function automatic logic [9:0] dr_deriv(input logic [6:0] ang);
    logic [9:0] d;
    case (ang)
      7'd3:  d = 10'd1023;  7'd6:  d = 10'd547;  7'd9:  d = 10'd372;
      7'd14: d = 10'd273;   7'd17: d = 10'd215;  7'd20: d = 10'd178;
      7'd23: d = 10'd151;   7'd26: d = 10'd132;  7'd29: d = 10'd116;
      7'd32: d = 10'd102;   7'd36: d = 10'd90;   7'd39: d = 10'd80;
      7'd42: d = 10'd71;    7'd45: d = 10'd64;   7'd48: d = 10'd57;
      7'd51: d = 10'd51;    7'd54: d = 10'd45;   7'd58: d = 10'd40;
      7'd61: d = 10'd35;    7'd64: d = 10'd31;   7'd67: d = 10'd27;
      7'd70: d = 10'd23;    7'd73: d = 10'd19;   7'd76: d = 10'd15;
      7'd81: d = 10'd11;    7'd84: d = 10'd7;    7'd87: d = 10'd3;
      default: d = 10'd0;
    endcase
    return d;
  endfunction

  function automatic logic [2:0] edge_lim(input logic [15:0] mx, input logic [15:0] org);
    logic [15:0] d;
    logic [2:0]  r;
    d = mx - org;
    if (mx < org)        r = 3'd0;
    else if (d > 16'd7)  r = 3'd7;
    else                 r = d[2:0];
    return r;
  endfunction

  // Two-tap interpolation done per component so no carry crosses component boundaries.
  function automatic logic [PW-1:0] blend(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                          input logic [4:0] sh);
    logic [PW-1:0]    r;
    logic [ACC_W-1:0] acc, rnd;
    r = '0;
    for (int k = 0; k < NCOMP; k++) begin
      acc = ACC_W'(a[k*BITDEPTH +: BITDEPTH]) * ACC_W'(6'd32 - {1'b0, sh})
          + ACC_W'(b[k*BITDEPTH +: BITDEPTH]) * ACC_W'(sh) + ACC_W'(5'd16);
      rnd = acc >> 5;
      r[k*BITDEPTH +: BITDEPTH] = (rnd > ACC_W'(PIX_MAX)) ? PIX_MAX : rnd[BITDEPTH-1:0];
    end
    return r;
  endfunction

  // Stage 1: capture every input each clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      plane_r <= 1'b0; have_left_r <= 1'b0; have_above_r <= 1'b0; filt_en_r <= 1'b0;
      mode_r <= 4'd0; delta_y_r <= 10'sd0; delta_uv_r <= 10'sd0; base_angle_r <= 10'sd0;
      ref_pix_r <= '0; max_x_r <= 16'd0; max_y_r <= 16'd0; x_r <= 16'd0; y_r <= 16'd0;
      w_r <= 10'd0; h_r <= 10'd0; above_r <= '0; left_r <= '0;
    end else begin
      plane_r <= plane; have_left_r <= haveLeft; have_above_r <= haveAbove;
      filt_en_r <= enable_intra_edge_filter; mode_r <= mode;
      delta_y_r <= AngleDeltaY; delta_uv_r <= AngleDeltaUV; base_angle_r <= base_angle;
      ref_pix_r <= referencePixel; max_x_r <= maxX; max_y_r <= maxY; x_r <= x; y_r <= y;
      w_r <= w; h_r <= h; above_r <= aboveRow; left_r <= leftCol;
    end
  end

  assign unused_s = ^{mode_r, filt_en_r};

  // Prediction angle and the derivative pair used by the interpolators.
  always_comb begin
    delta_s   = plane_r ? 12'(delta_uv_r) : 12'(delta_y_r);
    p_angle_s = 12'(base_angle_r) + delta_s * 12'sd3;
    fill_s    = (w_r != 10'd4) || (h_r != 10'd4) || (p_angle_s <= 12'sd0) || (p_angle_s >= 12'sd270);
    if (p_angle_s > 12'sd0 && p_angle_s < 12'sd90) begin
      dx_s = dr_deriv(7'(p_angle_s));
      dy_s = 10'd0;
    end else if (p_angle_s > 12'sd90 && p_angle_s < 12'sd180) begin
      dx_s = dr_deriv(7'(12'sd180 - p_angle_s));
      dy_s = dr_deriv(7'(p_angle_s - 12'sd90));
    end else if (p_angle_s > 12'sd180 && p_angle_s < 12'sd270) begin
      dx_s = 10'd0;
      dy_s = dr_deriv(7'(12'sd270 - p_angle_s));
    end else begin
      dx_s = 10'd0;
      dy_s = 10'd0;
    end
  end

  // Edge arrays: index 0 is the corner, 1..8 are samples 0..7 after frame clipping and substitution.
  always_comb begin
    lim_a_s = edge_lim(max_x_r, x_r);
    lim_l_s = edge_lim(max_y_r, y_r);
    ia_s = 3'd0;
    il_s = 3'd0;
    for (int k = 0; k < 9; k++) begin
      ea_s[k] = ref_pix_r;
      la_s[k] = ref_pix_r;
    end
    for (int k = 0; k < 8; k++) begin
      ia_s = (3'(k) > lim_a_s) ? lim_a_s : 3'(k);
      il_s = (3'(k) > lim_l_s) ? lim_l_s : 3'(k);
      if (have_above_r && have_left_r) begin
        ea_s[k+1] = above_r[ia_s];
        la_s[k+1] = left_r[il_s];
      end else if (have_above_r) begin
        ea_s[k+1] = above_r[ia_s];
        la_s[k+1] = above_r[0];
      end else if (have_left_r) begin
        ea_s[k+1] = left_r[0];
        la_s[k+1] = left_r[il_s];
      end else begin
        ea_s[k+1] = ref_pix_r;
        la_s[k+1] = ref_pix_r;
      end
    end
    if (have_above_r && have_left_r) begin
      ea_s[0] = ref_pix_r;
    end else if (have_above_r) begin
      ea_s[0] = above_r[0];
    end else if (have_left_r) begin
      ea_s[0] = left_r[0];
    end else begin
      ea_s[0] = ref_pix_r;
    end
    la_s[0] = ea_s[0];
  end

`ifdef INTRA_EDGE_FILTER_EN
  logic               filt_a_s, filt_l_s;
  logic signed [11:0] dist_a_s, dist_l_s;

  function automatic logic [PW-1:0] smooth(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                           input logic [PW-1:0] c);
    logic [PW-1:0]       r;
    logic [BITDEPTH+4:0] acc;
    r = '0;
    for (int k = 0; k < NCOMP; k++) begin
      acc = ((BITDEPTH+5)'(a[k*BITDEPTH +: BITDEPTH]) << 2) + ((BITDEPTH+5)'(b[k*BITDEPTH +: BITDEPTH]) << 3)
          + ((BITDEPTH+5)'(c[k*BITDEPTH +: BITDEPTH]) << 2) + (BITDEPTH+5)'(4'd8);
      r[k*BITDEPTH +: BITDEPTH] = acc[BITDEPTH+3:4];
    end
    return r;
  endfunction

  // Strength-1 smoothing on steep angles; the corner and the last sample stay untouched.
  always_comb begin
    dist_a_s = (p_angle_s >= 12'sd90)  ? (p_angle_s - 12'sd90)  : (12'sd90 - p_angle_s);
    dist_l_s = (p_angle_s >= 12'sd180) ? (p_angle_s - 12'sd180) : (12'sd180 - p_angle_s);
    filt_a_s = filt_en_r && (dist_a_s >= 12'sd56);
    filt_l_s = filt_en_r && (dist_l_s >= 12'sd56);
    for (int k = 0; k < 9; k++) begin
      af_s[k] = ea_s[k];
      lf_s[k] = la_s[k];
    end
    for (int k = 1; k < 8; k++) begin
      if (filt_a_s) af_s[k] = smooth(ea_s[k-1], ea_s[k], ea_s[k+1]);
      else          af_s[k] = ea_s[k];
      if (filt_l_s) lf_s[k] = smooth(la_s[k-1], la_s[k], la_s[k+1]);
      else          lf_s[k] = la_s[k];
    end
  end
`else
  // Edges go to the predictor unfiltered.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      af_s[k] = ea_s[k];
      lf_s[k] = la_s[k];
    end
  end
`endif

  // Per-sample directional prediction across zones 1, 2 and 3.
  always_comb begin
    idx_s  = 0;
    base_s = 0;
    bl_s   = 0;
    sh_s   = 5'd0;
    pred_s = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (fill_s) begin
          pred_s[i][j] = ref_pix_r;
        end else if (p_angle_s == 12'sd90) begin
          pred_s[i][j] = af_s[j+1];
        end else if (p_angle_s == 12'sd180) begin
          pred_s[i][j] = lf_s[i+1];
        end else if (p_angle_s < 12'sd90) begin
          idx_s  = (i + 1) * int'(dx_s);
          base_s = (idx_s >>> 6) + j;
          sh_s   = 5'(idx_s >>> 1);
          if (base_s >= 7) pred_s[i][j] = af_s[8];
          else             pred_s[i][j] = blend(af_s[4'(base_s + 1)], af_s[4'(base_s + 2)], sh_s);
        end else if (p_angle_s < 12'sd180) begin
          idx_s  = (j * 64) - (i + 1) * int'(dx_s);
          base_s = idx_s >>> 6;
          if (base_s >= -1) begin
            sh_s = 5'(idx_s >>> 1);
            pred_s[i][j] = blend(af_s[4'(base_s + 1)], af_s[4'(base_s + 2)], sh_s);
          end else begin
            idx_s  = (i * 64) - (j + 1) * int'(dy_s);
            base_s = idx_s >>> 6;
            bl_s   = (base_s < -1) ? -1 : ((base_s > 6) ? 6 : base_s);
            sh_s   = 5'(idx_s >>> 1);
            pred_s[i][j] = blend(lf_s[4'(bl_s + 1)], lf_s[4'(bl_s + 2)], sh_s);
          end
        end else begin
          idx_s  = (j + 1) * int'(dy_s);
          base_s = (idx_s >>> 6) + i;
          sh_s   = 5'(idx_s >>> 1);
          if (base_s >= 7) pred_s[i][j] = lf_s[8];
          else             pred_s[i][j] = blend(lf_s[4'(base_s + 1)], lf_s[4'(base_s + 2)], sh_s);
        end
      end
    end
  end

  // Stage 2: registered prediction.
  always_ff @(posedge clk) begin
    if (reset) pred <= '0;
    else       pred <= pred_s;
  end
endmodule

// File: tb/tb_control_directional_mode.sv
// Directed-vector bench for control_directional_mode: stimulus pushes expected blocks, a monitor pops and compares.
module tb_control_directional_mode;
  typedef logic [3:0][3:0][29:0] blk_t;

  logic              clk = 1'b0;
  logic              reset, plane, haveLeft, haveAbove, enable_intra_edge_filter;
  logic [3:0]        mode;
  logic signed [9:0] AngleDeltaY, AngleDeltaUV, base_angle;
  logic [29:0]       referencePixel;
  logic [15:0]       maxX, maxY, x, y;
  logic [9:0]        w, h;
  logic [7:0][29:0]  aboveRow, leftCol;
  blk_t              pred;

  blk_t  exp_q[$];
  string name_q[$];
  logic  issue = 1'b0;
  logic [1:0] vld_pipe = 2'b00;
  int    n_chk = 0;
  int    n_pass = 0;

  control_directional_mode dut (
    .clk(clk), .reset(reset), .plane(plane), .haveLeft(haveLeft), .haveAbove(haveAbove),
    .mode(mode), .AngleDeltaY(AngleDeltaY), .AngleDeltaUV(AngleDeltaUV),
    .referencePixel(referencePixel), .enable_intra_edge_filter(enable_intra_edge_filter),
    .maxX(maxX), .maxY(maxY), .base_angle(base_angle), .w(w), .h(h), .x(x), .y(y),
    .aboveRow(aboveRow), .leftCol(leftCol), .pred(pred)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] px(input int v);
    logic [9:0] c;
    c = 10'(v);
    return {c, c, c};
  endfunction

  task automatic defaults();
    plane = 1'b0; haveLeft = 1'b1; haveAbove = 1'b1; enable_intra_edge_filter = 1'b0;
    mode = 4'd5; AngleDeltaY = 10'sd0; AngleDeltaUV = 10'sd0; base_angle = 10'sd45;
    referencePixel = px(500); maxX = 16'd500; maxY = 16'd500; x = 16'd4; y = 16'd4;
    w = 10'd4; h = 10'd4;
    for (int k = 0; k < 8; k++) begin
      aboveRow[k] = px(10 * k);
      leftCol[k]  = px(100 + k);
    end
  endtask

  task automatic issue_vec(input string nm, input blk_t e);
    issue = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(posedge clk) vld_pipe <= {vld_pipe[0], issue};

  // Monitor: the block issued two clocks ago is on pred now.
  always @(negedge clk) begin
    blk_t  e;
    string nm;
    if (vld_pipe[1]) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL scoreboard_underflow: output with no expected block queued");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) begin
            n_chk++;
            if (pred[i][j] === e[i][j]) n_pass++;
            else $display("FAIL %s pred[%0d][%0d] got %h expected %h", nm, i, j, pred[i][j], e[i][j]);
          end
        end
      end
    end
  end

  initial begin
    blk_t e;
    int t135 [4][4] = '{'{500, 0, 10, 20}, '{100, 500, 0, 10}, '{101, 100, 500, 0}, '{102, 101, 100, 500}};
    int t67  [4][4] = '{'{4, 14, 24, 34}, '{8, 18, 28, 38}, '{13, 23, 33, 43}, '{17, 27, 37, 47}};
    int wait_cnt;

    defaults();
    reset = 1'b1;
    @(negedge clk); issue_vec("reset", '0);
    @(negedge clk); issue = 1'b0;
    @(negedge clk); reset = 1'b0;

    defaults(); haveLeft = 1'b0; maxY = 16'd20; enable_intra_edge_filter = 1'b1;
    for (int k = 0; k < 8; k++) begin aboveRow[k] = px(31); leftCol[k] = px(31); end
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = px(31);
    issue_vec("const31", e);

    @(negedge clk); defaults();
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = px(10 * (i + j + 1));
    issue_vec("zone1_45", e);

    @(negedge clk); defaults(); base_angle = 10'sd90;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = px(10 * j);
    issue_vec("angle90", e);

    @(negedge clk); defaults(); base_angle = 10'sd180;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = px(100 + i);
    issue_vec("angle180", e);

    @(negedge clk); defaults(); haveAbove = 1'b0; haveLeft = 1'b0; referencePixel = 30'd200;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = 30'd200;
    issue_vec("no_neighbours", e);

    @(negedge clk); defaults(); maxX = 16'd5; base_angle = 10'sd90;
    for (int k = 0; k < 8; k++) aboveRow[k] = px(k);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = px((j == 0) ? 0 : 1);
    issue_vec("clip_above", e);

    @(negedge clk); defaults(); base_angle = 10'sd99; AngleDeltaY = -10'sd3; AngleDeltaUV = 10'sd3;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = px(10 * j);
    issue_vec("luma_delta", e);

    @(negedge clk); defaults(); plane = 1'b1; base_angle = 10'sd189; AngleDeltaUV = -10'sd3; AngleDeltaY = 10'sd3;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = px(100 + i);
    issue_vec("chroma_delta", e);

    @(negedge clk); defaults(); base_angle = 10'sd270;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = px(500);
    issue_vec("angle270_fill", e);

    @(negedge clk); defaults(); base_angle = 10'sd3; AngleDeltaY = -10'sd2;
    issue_vec("angle_neg_fill", e);

    @(negedge clk); defaults(); w = 10'd8;
    issue_vec("size8_fill", e);

    @(negedge clk); defaults(); base_angle = 10'sd225;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = px(100 + i + j + 1);
    issue_vec("zone3_225", e);

    @(negedge clk); defaults(); base_angle = 10'sd135;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = px(t135[i][j]);
    issue_vec("zone2_135", e);

    @(negedge clk); defaults(); base_angle = 10'sd67;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = px(t67[i][j]);
    issue_vec("interp_67", e);

    @(negedge clk); defaults(); base_angle = 10'sd67; referencePixel = {10'd0, 10'd1023, 10'd1023};
    for (int k = 0; k < 8; k++) begin aboveRow[k] = {10'd0, 10'd1023, 10'd1023}; leftCol[k] = aboveRow[k]; end
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = {10'd0, 10'd1023, 10'd1023};
    issue_vec("no_carry", e);

    @(negedge clk); defaults(); haveAbove = 1'b0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = px(100);
    issue_vec("sub_above", e);

    @(negedge clk); defaults(); base_angle = 10'sd180; maxY = 16'd6;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = px(100 + ((i > 2) ? 2 : i));
    issue_vec("clip_left", e);

    @(negedge clk); issue = 1'b0;
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expected blocks never seen, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
